// File: rtl/ws28xx_pkg.sv
// Shared types and helpers for the WS28xx frame controller.
// Holds the controller state type, the pixel-width legality check and the byte scaler.
package ws28xx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic bit pix_w_legal(input int unsigned pix_w);
    return (pix_w == 24) || (pix_w == 32);
  endfunction

  // bright+1 makes 255 an exact identity and 0 a full blank.
  function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] bright);
    logic [16:0] prod;
    prod = {9'd0, b} * ({9'd0, bright} + 17'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/ws28xx_bright_scale.sv
// Combinational per-byte brightness scaling of one pixel word.
// Each colour byte is scaled independently by the frame brightness.
module ws28xx_bright_scale
  import ws28xx_pkg::*;
#(
  parameter int unsigned PIX_W = 24
) (
  input  logic [PIX_W-1:0] pix_i,
  input  logic [7:0]       bright_i,
  output logic [PIX_W-1:0] pix_o
);

  for (genvar k = 0; k < PIX_W / 8; k++) begin : g_byte
    assign pix_o[8*k +: 8] = scale_byte(pix_i[8*k +: 8], bright_i);
  end

endmodule

// File: rtl/ws28xx_frame_ctl.sv
// WS28xx frame controller: walks a linked pixel list in synchronous RAM,
// scales each pixel by the frame brightness and streams its bits over valid/ready.
module ws28xx_frame_ctl
  import ws28xx_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned PIX_W     = 24,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned MAX_PIX   = 2**ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    out_sync_i,
  input  logic [ADDR_W-1:0]       start_addr_i,
  input  logic [7:0]              bright_i,
  output logic                    bit_data_o,
  output logic                    bit_valid_o,
  output logic                    bit_last_o,
  input  logic                    bit_ready_i,
  output logic [ADDR_W-1:0]       ram_rd_addr_o,
  input  logic [ADDR_W+PIX_W-1:0] ram_rd_data_i,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    frame_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_PIX + 1);
  localparam int unsigned BC_W  = $clog2(PIX_W);

  if (!pix_w_legal(PIX_W)) begin : g_bad_pix_w
    $error("ws28xx_frame_ctl: PIX_W must be 24 or 32");
  end

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]  next_q, next_d;
  logic [7:0]         bright_q, bright_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PIX_W-1:0]   shreg_q, shreg_d;
  logic               pending_q, pending_d;
  logic               err_q, err_d;
  logic [PIX_W-1:0]   scaled;
  logic               pix_last_bit;
  logic               frame_end;

  ws28xx_bright_scale #(.PIX_W(PIX_W)) u_scale (
    .pix_i    (ram_rd_data_i[PIX_W-1:0]),
    .bright_i (bright_q),
    .pix_o    (scaled)
  );

  assign pix_last_bit = (bit_cnt_q == BC_W'(PIX_W - 1));
  assign frame_end    = (next_q == '0) || (pix_cnt_q == CNT_W'(MAX_PIX));

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    next_d    = next_q;
    bright_d  = bright_q;
    pix_cnt_d = pix_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    err_d     = err_q;
    pending_d = pending_q;
    if (state_q != ST_IDLE && out_sync_i) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (out_sync_i || pending_q) begin
          rd_addr_d = start_addr_i;
          bright_d  = bright_i;
          pix_cnt_d = '0;
          pending_d = 1'b0;
          err_d     = 1'b0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        next_d    = ram_rd_data_i[ADDR_W+PIX_W-1:PIX_W];
        shreg_d   = scaled;
        bit_cnt_d = '0;
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_ready_i) begin
          shreg_d   = MSB_FIRST ? {shreg_q[PIX_W-2:0], 1'b0} : {1'b0, shreg_q[PIX_W-1:1]};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (pix_last_bit) begin
            if (next_q == '0) begin
              state_d = ST_DONE;
            end else if (pix_cnt_q == CNT_W'(MAX_PIX)) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              rd_addr_d = next_q;
              state_d   = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      next_q    <= '0;
      bright_q  <= '0;
      pix_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      next_q    <= next_d;
      bright_q  <= bright_d;
      pix_cnt_q <= pix_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign bit_valid_o   = (state_q == ST_SHIFT);
  assign bit_data_o    = bit_valid_o & (MSB_FIRST ? shreg_q[PIX_W-1] : shreg_q[0]);
  assign bit_last_o    = bit_valid_o & pix_last_bit & frame_end;
  assign ram_rd_addr_o = rd_addr_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign frame_done_o  = (state_q == ST_DONE);
  assign frame_err_o   = (state_q == ST_DONE) & err_q;

endmodule

// File: tb/tb_ws28xx_frame_ctl.sv
// Self-checking bench for ws28xx_frame_ctl: an RGB/MSB-first instance and an
// RGBW/LSB-first 3-bit-address instance, each checked against a list-walking model.
module tb_ws28xx_frame_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sync = '0;
  logic [1:0]  rdy = 2'b11;
  logic [7:0]  sa_a = '0, br_a = '0;
  logic [2:0]  sa_b = '0;
  logic [7:0]  br_b = '0;
  logic [1:0]  vld, dat, lst, bsy, dn, er;
  logic [7:0]  ad_a;
  logic [2:0]  ad_b;
  logic [31:0] rd_a = '0;
  logic [34:0] rd_b = '0;

  logic [7:0]  m_nxt [2][256];
  logic [31:0] m_pix [2][256];

  int n_cmp = 0, n_err = 0;
  bit rnd = 1'b0;

  // model state
  int m_active [2], m_gap [2], m_done [2], m_pend [2], m_err [2], rdp [2], wrp [2];
  bit expb [2][0:8191];
  int expa [2][0:255];
  // observation logs
  logic [31:0] cap [2];
  int capn [2], dcnt [2], ecnt [2];
  int obs_addr [2][0:255];

  always #5 clk = ~clk;

  ws28xx_frame_ctl #(.ADDR_W(8), .PIX_W(24), .MSB_FIRST(1'b1), .MAX_PIX(256)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .out_sync_i(sync[0]), .start_addr_i(sa_a), .bright_i(br_a),
    .bit_data_o(dat[0]), .bit_valid_o(vld[0]), .bit_last_o(lst[0]), .bit_ready_i(rdy[0]),
    .ram_rd_addr_o(ad_a), .ram_rd_data_i(rd_a), .busy_o(bsy[0]), .frame_done_o(dn[0]),
    .frame_err_o(er[0]));

  ws28xx_frame_ctl #(.ADDR_W(3), .PIX_W(32), .MSB_FIRST(1'b0), .MAX_PIX(8)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .out_sync_i(sync[1]), .start_addr_i(sa_b), .bright_i(br_b),
    .bit_data_o(dat[1]), .bit_valid_o(vld[1]), .bit_last_o(lst[1]), .bit_ready_i(rdy[1]),
    .ram_rd_addr_o(ad_b), .ram_rd_data_i(rd_b), .busy_o(bsy[1]), .frame_done_o(dn[1]),
    .frame_err_o(er[1]));

  always @(posedge clk) begin
    rd_a <= {m_nxt[0][ad_a], m_pix[0][ad_a][23:0]};
    rd_b <= {m_nxt[1][{5'd0, ad_b}][2:0], m_pix[1][{5'd0, ad_b}]};
  end

  function automatic int pwf(input int d);  return (d != 0) ? 32 : 24; endfunction
  function automatic int maxp(input int d); return (d != 0) ? 8 : 256; endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Walk the list from the sampled start address and lay out the expected bit stream.
  task automatic build(input int d);
    int a, p, pw, b, brv;
    logic [31:0] px, sp;
    pw = pwf(d);
    a = (d != 0) ? int'(sa_b) : int'(sa_a);
    brv = (d != 0) ? int'(br_b) : int'(br_a);
    wrp[d] = 0;
    rdp[d] = 0;
    for (p = 0; p < maxp(d); p++) begin
      expa[d][p] = a;
      px = m_pix[d][a];
      sp = '0;
      for (int k = 0; k < pw / 8; k++) begin
        b = int'((px >> (8 * k)) & 32'hFF);
        sp = sp | (32'((b * (brv + 1)) / 256) << (8 * k));
      end
      for (int i = 0; i < pw; i++) expb[d][wrp[d] + i] = (d != 0) ? sp[i] : sp[pw - 1 - i];
      wrp[d] += pw;
      if (m_nxt[d][a] == 8'd0) break;
      a = int'(m_nxt[d][a]);
    end
    m_err[d] = (p == maxp(d)) ? 1 : 0;
  endtask

  task automatic step(input int d);
    int ev, av, pw;
    pw = pwf(d);
    av = (d != 0) ? int'(ad_b) : int'(ad_a);
    if (!rst_n) begin
      m_active[d] = 0; m_gap[d] = 0; m_done[d] = 0; m_pend[d] = 0;
      chk("rst_valid", int'(vld[d]), 0);
      chk("rst_busy", int'(bsy[d]), 0);
      chk("rst_done", int'(dn[d]), 0);
      chk("rst_err", int'(er[d]), 0);
      chk("rst_data", int'(dat[d]), 0);
      chk("rst_last", int'(lst[d]), 0);
      chk("rst_addr", av, 0);
      return;
    end
    ev = (m_active[d] != 0 && m_gap[d] == 0 && m_done[d] == 0) ? 1 : 0;
    chk("valid", int'(vld[d]), ev);
    chk("busy", int'(bsy[d]), m_active[d]);
    chk("done", int'(dn[d]), m_done[d]);
    chk("err", int'(er[d]), (m_done[d] != 0 && m_err[d] != 0) ? 1 : 0);
    if (dn[d]) dcnt[d]++;
    if (er[d]) ecnt[d]++;
    if (ev != 0) begin
      chk("data", int'(dat[d]), int'(expb[d][rdp[d]]));
      chk("last", int'(lst[d]), (rdp[d] == wrp[d] - 1) ? 1 : 0);
      if (rdp[d] % pw == 0) chk("rd_addr", av, expa[d][rdp[d] / pw]);
    end
    if (vld[d] && rdy[d]) begin
      if (capn[d] % pw == 0 && capn[d] / pw < 256) obs_addr[d][capn[d] / pw] = av;
      if (d == 0) cap[0] = {cap[0][30:0], dat[0]};
      else        cap[1] = {dat[1], cap[1][31:1]};
      capn[d]++;
    end
    if (m_active[d] == 0) begin
      if (sync[d] || m_pend[d] != 0) begin
        build(d);
        m_pend[d] = 0;
        m_active[d] = 1;
        m_gap[d] = 2;
      end
    end else if (m_done[d] != 0) begin
      m_done[d] = 0;
      m_active[d] = 0;
      if (sync[d]) m_pend[d] = 1;
    end else if (m_gap[d] > 0) begin
      m_gap[d]--;
      if (sync[d]) m_pend[d] = 1;
    end else begin
      if (sync[d]) m_pend[d] = 1;
      if (rdy[d]) begin
        rdp[d]++;
        if (rdp[d] == wrp[d]) m_done[d] = 1;
        else if (rdp[d] % pw == 0) m_gap[d] = 2;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) step(d);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd) begin
      rdy[0] = ($urandom_range(0, 99) >= 30);
      rdy[1] = ($urandom_range(0, 99) >= 30);
    end else begin
      rdy = 2'b11;
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      cap[d] = '1; capn[d] = 0; dcnt[d] = 0; ecnt[d] = 0;
    end
  endtask

  task automatic start(input int d, input int addr, input int br);
    if (d == 0) begin sa_a = 8'(addr); br_a = 8'(br); end
    else        begin sa_b = 3'(addr); br_b = 8'(br); end
    sync[d] = 1'b1;
    cyc();
    sync[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    cyc();
    while ((bsy[d] || m_active[d] != 0 || m_pend[d] != 0) && n < 5000) begin
      cyc();
      n++;
    end
    chk("wait_idle_timeout", (n >= 5000) ? 1 : 0, 0);
  endtask

  task automatic chain_a();
    m_nxt[0][5] = 8'd9; m_nxt[0][9] = 8'd2; m_nxt[0][2] = 8'd0;
    m_pix[0][5] = 32'h123456; m_pix[0][9] = 32'hC0FFEE; m_pix[0][2] = 32'h0A0B0C;
  endtask

  initial begin
    int n, len, base, ad [5];
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin m_nxt[d][i] = '0; m_pix[d][i] = '0; end
      m_active[d] = 0; m_gap[d] = 0; m_done[d] = 0; m_pend[d] = 0; m_err[d] = 0;
      rdp[d] = 0; wrp[d] = 0;
    end
    clr();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // single pixel, full brightness
    clr();
    m_pix[0][0] = 32'hA50F3C; m_nxt[0][0] = 8'd0;
    start(0, 0, 255);
    wait_idle(0);
    chk("single_bits", int'(cap[0][23:0]), 32'hA50F3C);
    chk("single_nbits", capn[0], 24);
    chk("single_done", dcnt[0], 1);

    // three-pixel chain 5 -> 9 -> 2
    clr();
    chain_a();
    start(0, 5, 255);
    wait_idle(0);
    chk("chain_nbits", capn[0], 72);
    chk("chain_addr0", obs_addr[0][0], 5);
    chk("chain_addr1", obs_addr[0][1], 9);
    chk("chain_addr2", obs_addr[0][2], 2);
    chk("chain_last_pix", int'(cap[0][23:0]), 32'h0A0B0C);

    // brightness scaling on both widths
    clr();
    m_pix[0][3] = 32'hFF8001; m_nxt[0][3] = 8'd0;
    m_pix[1][4] = 32'hFFFFFFFF; m_nxt[1][4] = 8'd0;
    start(0, 3, 127);
    start(1, 4, 0);
    wait_idle(0);
    wait_idle(1);
    chk("bright127", int'(cap[0][23:0]), 32'h7F4000);
    chk("bright0_rgbw", int'(cap[1]), 0);
    chk("bright0_nbits", capn[1], 32);

    // backpressure on the same chain
    clr();
    rnd = 1'b1;
    start(0, 5, 255);
    wait_idle(0);
    chk("bp_nbits", capn[0], 72);
    chk("bp_last_pix", int'(cap[0][23:0]), 32'h0A0B0C);

    // randomized frames on both instances
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 5);
      base = $urandom_range(0, 254);
      for (int i = 0; i < len; i++) ad[i] = (base + i * 37) % 255 + 1;
      for (int i = 0; i < len; i++) begin
        m_pix[0][ad[i]] = $urandom & 32'hFFFFFF;
        m_nxt[0][ad[i]] = (i == len - 1) ? 8'd0 : 8'(ad[i + 1]);
      end
      n = $urandom_range(0, 7);
      m_pix[1][n] = $urandom;
      m_nxt[1][n] = 8'd0;
      start(0, ad[0], $urandom_range(0, 255));
      start(1, n, $urandom_range(0, 255));
      wait_idle(0);
      wait_idle(1);
    end

    // runaway loop 1 -> 2 -> 1 on the 3-bit instance
    clr();
    m_nxt[1][1] = 8'd2; m_nxt[1][2] = 8'd1;
    m_pix[1][1] = 32'h01020304; m_pix[1][2] = 32'hF0E0D0C0;
    start(1, 1, 200);
    wait_idle(1);
    chk("runaway_nbits", capn[1], 256);
    chk("runaway_done", dcnt[1], 1);
    chk("runaway_err", ecnt[1], 1);

    // two syncs during a busy frame -> exactly one restart
    clr();
    rnd = 1'b0;
    start(0, 5, 255);
    repeat (10) cyc();
    start(0, 5, 255);
    repeat (20) cyc();
    start(0, 5, 255);
    wait_idle(0);
    chk("pend_done", dcnt[0], 2);
    chk("pend_nbits", capn[0], 144);

    // reset in the middle of a shift
    clr();
    start(0, 5, 255);
    n = 0;
    while (!vld[0] && n < 50) begin cyc(); n++; end
    chk("rst_wait_timeout", (n >= 50) ? 1 : 0, 0);
    repeat (5) cyc();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    chk("rst_no_done", dcnt[0], 0);
    chk("rst_idle", int'(bsy[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
